// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one cacheline adaptor between icache and dcache.
// Optional macro ARB_ROUND_ROBIN_EN: alternate ties using last_served.
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              ca_read,
    output logic              ca_write,
    output logic [ADDR_W-1:0] ca_address,
    output logic [LINE_W-1:0] ca_wdata,
    input  logic [LINE_W-1:0] ca_rdata,
    input  logic              ca_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_last_served;
    logic   w_i_req;
    logic   w_d_req;
    logic   w_pick_d;

    assign w_i_req = i_pmem_read;
    assign w_d_req = d_pmem_read | d_pmem_write;

`ifdef ARB_ROUND_ROBIN_EN
    assign w_pick_d = ~r_last_served;
`else
    assign w_pick_d = 1'b1;
`endif

    // Read data is broadcast; resp tells each cache when it is theirs.
    assign i_pmem_rdata = ca_rdata;
    assign d_pmem_rdata = ca_rdata;

    // State register and record of which cache finished last.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_last_served <= 1'b0;
        end else begin
            r_state <= w_next;
            if (ca_resp && r_state == SERVE_I)
                r_last_served <= 1'b0;
            else if (ca_resp && r_state == SERVE_D)
                r_last_served <= 1'b1;
            else
                r_last_served <= r_last_served;
        end
    end

    // Arbitrate in IDLE; hold the grant until the adaptor responds.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_i_req && w_d_req)
                    w_next = w_pick_d ? SERVE_D : SERVE_I;
                else if (w_d_req)
                    w_next = SERVE_D;
                else if (w_i_req)
                    w_next = SERVE_I;
            end
            SERVE_I, SERVE_D: begin
                if (ca_resp)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Route the granted cache onto the adaptor port.
    always_comb begin
        ca_read     = 1'b0;
        ca_write    = 1'b0;
        ca_address  = '0;
        ca_wdata    = '0;
        i_pmem_resp = 1'b0;
        d_pmem_resp = 1'b0;
        unique case (r_state)
            SERVE_I: begin
                ca_read     = i_pmem_read;
                ca_address  = i_pmem_address;
                i_pmem_resp = ca_resp;
            end
            SERVE_D: begin
                ca_read     = d_pmem_read;
                ca_write    = d_pmem_write;
                ca_address  = d_pmem_address;
                ca_wdata    = d_pmem_wdata;
                d_pmem_resp = ca_resp;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single cacheline adaptor / physical-memory port between the instruction cache and the data cache.
- Accepts one 256-bit line transaction at a time from either cache.
- Holds the grant until the adaptor responds, then returns to idle to re-arbitrate.
- Sits between the two cache controllers' pmem interfaces and the cacheline adaptor.

Parameters:
ADDR_W, 32, physical address width
LINE_W, 256, cacheline width in bits

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous, active-high reset
i_pmem_read  in  1  icache line-read request
i_pmem_address  in  ADDR_W  icache line address
i_pmem_rdata  out  LINE_W  line data to icache
i_pmem_resp  out  1  icache transaction done
d_pmem_read  in  1  dcache line-read request
d_pmem_write  in  1  dcache line write-back request
d_pmem_address  in  ADDR_W  dcache line address
d_pmem_wdata  in  LINE_W  dcache write-back data
d_pmem_rdata  out  LINE_W  line data to dcache
d_pmem_resp  out  1  dcache transaction done
ca_read  out  1  read request to cacheline adaptor
ca_write  out  1  write request to cacheline adaptor
ca_address  out  ADDR_W  address to adaptor
ca_wdata  out  LINE_W  write data to adaptor
ca_rdata  in  LINE_W  read data from adaptor
ca_resp  in  1  adaptor transaction done (1-cycle pulse)

Behaviour:
- State register values: IDLE, SERVE_I, SERVE_D. Reset value is IDLE.
- Outputs in IDLE:
  - ca_read = ca_write = 0.
  - i_pmem_resp = d_pmem_resp = 0.
  - ca_address = 0, ca_wdata = 0.
- Data broadcast: i_pmem_rdata and d_pmem_rdata are driven from ca_rdata in every state. The resp signal qualifies which requester may use it.
- IDLE transitions, evaluated every cycle:
  - Only the icache requesting (i_pmem_read): go to SERVE_I.
  - Only the dcache requesting (d_pmem_read | d_pmem_write): go to SERVE_D.
  - Both requesting: the winner is chosen by the arbitration policy (see Optional Feature).
  - Neither requesting: stay in IDLE.
- Grant latency: one cycle from request to ca_read/ca_write assertion. The request is sampled in IDLE; outputs are asserted in the SERVE state.
- SERVE_I outputs:
  - ca_read = i_pmem_read, ca_write = 0, ca_address = i_pmem_address.
  - i_pmem_resp = ca_resp.
  - d_pmem_resp = 0.
- SERVE_D outputs:
  - ca_read = d_pmem_read, ca_write = d_pmem_write.
  - ca_address = d_pmem_address, ca_wdata = d_pmem_wdata.
  - d_pmem_resp = ca_resp.
  - i_pmem_resp = 0.
- SERVE exit: on ca_resp, go to IDLE. The next cycle drives ca_read = ca_write = 0, so the adaptor always sees at least one idle cycle between transactions.
- Grant holding:
  - The grant is held until ca_resp regardless of the requester's lines. A request drop mid-transaction is a protocol violation; the arbiter does not abort.
  - The dcache write-back then refill arrives as two separate transactions. The refill re-arbitrates in IDLE, so an icache request may interleave between them.
- Simultaneous d_pmem_read and d_pmem_write is illegal. If it occurs, both are forwarded unchanged; no check is made.
- last_served: a 1-bit register updated on each ca_resp in SERVE_x (0 = I, 1 = D). Reset value is 0.
- Reset mid-transaction: rst in any state forces IDLE on the next edge and clears last_served. The adaptor and the caches are reset simultaneously.
- Purely combinational path exists from ca_resp to i/d_pmem_resp. There is no path from requester inputs to their own resp.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: on a tie in IDLE, the requester not equal to last_served wins. After reset (last_served = I), the first tie goes to D, then alternation follows. This bounds starvation to one transaction.
- Undefined: fixed priority; the dcache always wins ties. last_served is still maintained but unused for arbitration.

Test Plan:
- Lone icache read:
  - Stimulus: i_pmem_read = 1, address 0x0000_1000 in cycle 0; ca_resp pulses in cycle 5 with rdata 0xAA..AA.
  - Response: ca_read = 1 with address 0x1000 in cycles 1–5; i_pmem_resp = 1 only in cycle 5; ca_read = 0 in cycle 6.
- Dcache write-back then refill:
  - Stimulus: d_pmem_write, address 0x2000, wdata 0x55..55; ca_resp; then d_pmem_read, address 0x3000; ca_resp.
  - Response: the write appears on ca_* with exact data; one idle cycle; then the read; d_pmem_resp pulses twice; i_pmem_resp stays 0.
- Tie, macro undefined:
  - Stimulus: i and d request in the same cycle, twice in a row.
  - Response: D is served both times; I is served only after D drops its request.
- Tie, ARB_ROUND_ROBIN_EN:
  - Stimulus: back-to-back ties after reset.
  - Response: grant order is D, I, D, I.
- Interleave:
  - Stimulus: the icache requests during the dcache write-back; the dcache refill follows immediately.
  - Response (macro defined): the icache is served between the write-back and the refill. The macro-undefined order is covered by the fixed-priority tie scenario.
- Reset mid-SERVE_D:
  - Stimulus: rst asserted for 1 cycle while ca_write = 1.
  - Response: the next cycle has ca_write = 0 and both resp = 0; the state is IDLE; the first tie after reset goes to D.
